// File: rtl/sba_interconnect_if.sv
// Bus bundle for sba_interconnect.
// Holds every master-side and slave-side signal of the interconnect.
//   slave  modport : the interconnect's view. It samples the i_* signals
//                    and drives the o_* signals.
//   master modport : the surrounding system's view (masters, slaves, fault
//                    logic). It drives the i_* signals and samples the o_*.
// Port summary:
//   i_m_addr/i_m_dat_w/i_m_we/i_m_stb  packed per-master request fields
//   o_m_ack/o_m_err/o_m_dat_r          master response
//   o_s_addr/o_s_dat_w/o_s_we/o_s_stb  broadcast slave request, one-hot strobe
//   i_s_ack/i_s_dat_r                  per-slave response
//   o_fault_valid/addr/master, i_fault_clr  sticky fault capture
interface sba_interconnect_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int MW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
);
    logic [32*NUM_MASTERS-1:0] i_m_addr;
    logic [32*NUM_MASTERS-1:0] i_m_dat_w;
    logic [4*NUM_MASTERS-1:0]  i_m_we;
    logic [NUM_MASTERS-1:0]    i_m_stb;
    logic [NUM_MASTERS-1:0]    o_m_ack;
    logic [NUM_MASTERS-1:0]    o_m_err;
    logic [31:0]               o_m_dat_r;
    logic [31:0]               o_s_addr;
    logic [31:0]               o_s_dat_w;
    logic [3:0]                o_s_we;
    logic [NUM_SLAVES-1:0]     o_s_stb;
    logic [NUM_SLAVES-1:0]     i_s_ack;
    logic [32*NUM_SLAVES-1:0]  i_s_dat_r;
    logic                      o_fault_valid;
    logic [31:0]               o_fault_addr;
    logic [MW-1:0]             o_fault_master;
    logic                      i_fault_clr;

    modport slave (
        input  i_m_addr, i_m_dat_w, i_m_we, i_m_stb, i_s_ack, i_s_dat_r, i_fault_clr,
        output o_m_ack, o_m_err, o_m_dat_r, o_s_addr, o_s_dat_w, o_s_we, o_s_stb,
               o_fault_valid, o_fault_addr, o_fault_master
    );

    modport master (
        output i_m_addr, i_m_dat_w, i_m_we, i_m_stb, i_s_ack, i_s_dat_r, i_fault_clr,
        input  o_m_ack, o_m_err, o_m_dat_r, o_s_addr, o_s_dat_w, o_s_we, o_s_stb,
               o_fault_valid, o_fault_addr, o_fault_master
    );
endinterface

// File: rtl/sba_interconnect.sv
// sba_interconnect: round-robin N-master to M-slave SBA bus interconnect.
// A two-state FSM (IDLE/BUSY) grants one master at a time. The slave is
// decoded from addr[SEL_HI:SEL_LO]. Unmapped or hung accesses end with an
// error acknowledge, and the first such fault is latched for software.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : sba_interconnect_if.slave, carrying all master/slave/fault signals
module sba_interconnect #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int SEL_HI      = 31,
    parameter int SEL_LO      = 28,
    parameter int TIMEOUT     = 255,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input logic               i_clk,
    input logic               i_rst,
    sba_interconnect_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] grant_q, grant_d;
    logic [MW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_valid_q, fault_valid_d;
    logic [31:0]   fault_addr_q, fault_addr_d;
    logic [MW-1:0] fault_master_q, fault_master_d;

    logic                  busy, mapped, ack_hit, err, term, found;
    logic [31:0]           g_addr, g_dat_w, sel_idx;
    logic [3:0]            g_we;
    logic [SW-1:0]         slv;
    logic [NUM_SLAVES-1:0] s_stb;
    logic [NUM_MASTERS-1:0] m_ack, m_err;
    logic [31:0]           m_dat_r;
    int                    idx;

    // Decode and response path: purely combinational from state, grant and i_s_ack.
    always_comb begin
        busy    = (state_q == BUSY);
        g_addr  = bus.i_m_addr[32*int'(grant_q) +: 32];
        g_dat_w = bus.i_m_dat_w[32*int'(grant_q) +: 32];
        g_we    = bus.i_m_we[4*int'(grant_q) +: 4];
        sel_idx = 32'(g_addr[SEL_HI:SEL_LO]);
        mapped  = (sel_idx < 32'(NUM_SLAVES));
        slv     = sel_idx[SW-1:0];
        ack_hit = busy && mapped && bus.i_s_ack[slv];
        // The slave ack takes priority over a timeout in the same cycle.
        // The strobe stays up through the timeout cycle so a last-moment ack is still honoured.
        err     = busy && (!mapped ||
                  ((TIMEOUT != 0) && !ack_hit && (cnt_q == CW'(TIMEOUT))));
        term    = ack_hit || err;

        s_stb = '0;
        if (busy && mapped) s_stb[slv] = 1'b1;
        m_ack = '0;
        m_err = '0;
        if (term) m_ack[grant_q] = 1'b1;
        if (err)  m_err[grant_q] = 1'b1;
        m_dat_r = ack_hit ? bus.i_s_dat_r[32*int'(slv) +: 32] : 32'h0;
    end

    // Next-state: arbitration, timeout counter and fault capture.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        fault_valid_d  = fault_valid_q;
        fault_addr_d   = fault_addr_q;
        fault_master_d = fault_master_q;
        found          = 1'b0;
        idx            = 0;

        if (state_q == IDLE) begin
            cnt_d = '0;
            // Rotating search starting just after the last served master.
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                idx = (int'(last_q) + i) % NUM_MASTERS;
                if (!found && bus.i_m_stb[idx]) begin
                    found   = 1'b1;
                    grant_d = MW'(idx);
                end
            end
            if (found) state_d = BUSY;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (term) begin
                state_d = IDLE;
                last_d  = grant_q;
            end
        end

        // A new fault wins over a simultaneous clear, so nothing is lost.
        if (err && (!fault_valid_q || bus.i_fault_clr)) begin
            fault_valid_d  = 1'b1;
            fault_addr_d   = g_addr;
            fault_master_d = grant_q;
        end else if (bus.i_fault_clr) begin
            fault_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            last_q         <= MW'(NUM_MASTERS - 1);
            cnt_q          <= '0;
            fault_valid_q  <= 1'b0;
            fault_addr_q   <= '0;
            fault_master_q <= '0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            fault_valid_q  <= fault_valid_d;
            fault_addr_q   <= fault_addr_d;
            fault_master_q <= fault_master_d;
        end
    end

    assign bus.o_s_addr       = busy ? g_addr  : 32'h0;
    assign bus.o_s_dat_w      = busy ? g_dat_w : 32'h0;
    assign bus.o_s_we         = busy ? g_we    : 4'h0;
    assign bus.o_s_stb        = s_stb;
    assign bus.o_m_ack        = m_ack;
    assign bus.o_m_err        = m_err;
    assign bus.o_m_dat_r      = m_dat_r;
    assign bus.o_fault_valid  = fault_valid_q;
    assign bus.o_fault_addr   = fault_addr_q;
    assign bus.o_fault_master = fault_master_q;
endmodule

// File: tb/tb_sba_interconnect.sv
// Directed bench for sba_interconnect: 2 masters, 4 slaves, TIMEOUT=8.
// Slaves ack after a per-slave latency; responses are scoreboarded.
module tb_sba_interconnect;
    localparam int NM = 2;
    localparam int NS = 4;

    logic clk;
    logic rst;

    sba_interconnect_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .MW(1)) bus ();

    sba_interconnect #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SEL_HI(31), .SEL_LO(28), .TIMEOUT(8)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models: ack once the strobe has been high for lat[s] earlier cycles.
    logic [7:0]  lat  [NS];
    logic [31:0] sdat [NS];
    logic [7:0]  scnt [NS];

    always @(posedge clk) begin
        for (int s = 0; s < NS; s++) begin
            if (rst) scnt[s] <= 8'd0;
            else     scnt[s] <= bus.o_s_stb[s] ? scnt[s] + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        bus.i_s_ack   = '0;
        bus.i_s_dat_r = '0;
        for (int s = 0; s < NS; s++) begin
            bus.i_s_ack[s]            = bus.o_s_stb[s] && (scnt[s] == lat[s]);
            bus.i_s_dat_r[32*s +: 32] = sdat[s];
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          m;
        logic        err;
        logic [31:0] dat;
    } exp_t;
    exp_t sb_q[$];

    task automatic push(input int m, input logic err, input logic [31:0] dat);
        exp_t e;
        e.m = m; e.err = err; e.dat = dat;
        sb_q.push_back(e);
    endtask

    // Response monitor: every master ack is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.o_m_ack != '0) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ack", 32'(bus.o_m_ack), 32'h0);
            end else begin
                e = sb_q.pop_front();
                check("sb_ack_master", 32'(bus.o_m_ack), 32'(1 << e.m));
                check("sb_err", 32'(bus.o_m_err), e.err ? 32'(1 << e.m) : 32'h0);
                check("sb_dat_r", bus.o_m_dat_r, e.dat);
            end
        end
    end

    int          rec_ack_cyc, rec_stb_cyc;
    logic [3:0]  rec_stb_val, rec_we;
    logic [31:0] rec_addr, rec_dw;

    // Single transfer from master m; records ack cycle (cycle 0 = drive cycle).
    task automatic xfer(input int m, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] we, input logic exp_err, input logic [31:0] exp_dat);
        bus.i_m_addr[32*m +: 32] = addr;
        bus.i_m_dat_w[32*m +: 32] = wd;
        bus.i_m_we[4*m +: 4] = we;
        bus.i_m_stb[m] = 1'b1;
        push(m, exp_err, exp_dat);
        rec_ack_cyc = -1; rec_stb_cyc = 0; rec_stb_val = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.o_s_stb != '0) begin
                rec_stb_cyc++;
                if (rec_stb_val == '0) rec_stb_val = bus.o_s_stb;
            end
            if (bus.o_m_ack[m]) begin
                rec_ack_cyc = c;
                rec_addr = bus.o_s_addr; rec_dw = bus.o_s_dat_w; rec_we = bus.o_s_we;
                break;
            end
        end
        @(posedge clk); #1;
        bus.i_m_stb[m] = 1'b0;
    endtask

    // Both masters hold stb until n acks have been seen in total.
    task automatic wait_acks(input int n, output int c0, output int c1, output int first);
        c0 = 0; c1 = 0; first = -1;
        for (int c = 0; c < 80 && (c0 + c1) < n; c++) begin
            @(negedge clk);
            if (bus.o_m_ack[0]) begin c0++; if (first < 0) first = 0; end
            if (bus.o_m_ack[1]) begin c1++; if (first < 0) first = 1; end
        end
        @(posedge clk); #1;
        bus.i_m_stb = '0;
    endtask

    task automatic fault_clear();
        bus.i_fault_clr = 1'b1;
        @(posedge clk); #1;
        bus.i_fault_clr = 1'b0;
    endtask

    int c0, c1, first;

    initial begin
        rst = 1'b1;
        bus.i_m_addr = '0; bus.i_m_dat_w = '0; bus.i_m_we = '0; bus.i_m_stb = '0;
        bus.i_fault_clr = 1'b0;
        for (int s = 0; s < NS; s++) lat[s] = 8'd1;
        sdat[0] = 32'h0000_1111; sdat[1] = 32'hDEAD_BEEF;
        sdat[2] = 32'h2222_5A5A; sdat[3] = 32'h3333_A5A5;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_ack", 32'(bus.o_m_ack), 32'h0);
        check("rst_s_stb", 32'(bus.o_s_stb), 32'h0);
        check("rst_fault_valid", 32'(bus.o_fault_valid), 32'h0);
        check("rst_fault_addr", bus.o_fault_addr, 32'h0);
        check("rst_s_addr", bus.o_s_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single read from slave 1
        xfer(0, 32'h1000_0010, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
        check("t1_ack_cycle", 32'(rec_ack_cyc), 32'd2);
        check("t1_stb_onehot", 32'(rec_stb_val), 32'h2);
        check("t1_stb_cycles", 32'(rec_stb_cyc), 32'd2);
        check("t1_s_addr", rec_addr, 32'h1000_0010);

        // Write from master 1 to slave 3: broadcast fields follow the grant
        xfer(1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h3333_A5A5);
        check("t1b_ack_cycle", 32'(rec_ack_cyc), 32'd2);
        check("t1b_stb_onehot", 32'(rec_stb_val), 32'h8);
        check("t1b_s_dat_w", rec_dw, 32'hCAFE_F00D);
        check("t1b_s_we", 32'(rec_we), 32'hF);

        // Round-robin with both masters holding stb to slave 0
        bus.i_m_addr = {32'h0000_0080, 32'h0000_0040};
        push(0, 1'b0, 32'h0000_1111); push(1, 1'b0, 32'h0000_1111);
        push(0, 1'b0, 32'h0000_1111); push(1, 1'b0, 32'h0000_1111);
        bus.i_m_stb = 2'b11;
        wait_acks(4, c0, c1, first);
        check("t2_acks_m0", 32'(c0), 32'd2);
        check("t2_acks_m1", 32'(c1), 32'd2);
        check("t2_first", 32'(first), 32'd0);

        // Unmapped write from master 1
        xfer(1, 32'h5000_0000, 32'h0BAD_0BAD, 4'hF, 1'b1, 32'h0);
        check("t3_ack_cycle", 32'(rec_ack_cyc), 32'd1);
        check("t3_no_stb", 32'(rec_stb_cyc), 32'd0);
        check("t3_fault_valid", 32'(bus.o_fault_valid), 32'h1);
        check("t3_fault_addr", bus.o_fault_addr, 32'h5000_0000);
        check("t3_fault_master", 32'(bus.o_fault_master), 32'h1);

        // Hung slave 2: timeout and sticky fault
        fault_clear();
        check("t4_clr_valid", 32'(bus.o_fault_valid), 32'h0);
        lat[2] = 8'd255;
        xfer(0, 32'h2000_0100, 32'h0, 4'h0, 1'b1, 32'h0);
        check("t4_ack_cycle", 32'(rec_ack_cyc), 32'd9);
        check("t4_stb_cycles", 32'(rec_stb_cyc), 32'd9);
        check("t4_fault_addr", bus.o_fault_addr, 32'h2000_0100);
        check("t4_fault_master", 32'(bus.o_fault_master), 32'h0);
        xfer(1, 32'h2000_0200, 32'h0, 4'h0, 1'b1, 32'h0);
        check("t4b_ack_cycle", 32'(rec_ack_cyc), 32'd9);
        check("t4b_fault_kept", bus.o_fault_addr, 32'h2000_0100);
        check("t4b_master_kept", 32'(bus.o_fault_master), 32'h0);

        // Third hang with clear pulsed in the error-ack cycle
        bus.i_m_addr[31:0] = 32'h2000_0300;
        bus.i_m_stb[0] = 1'b1;
        push(0, 1'b1, 32'h0);
        repeat (9) @(posedge clk);
        #1 bus.i_fault_clr = 1'b1;
        @(negedge clk);
        check("t4c_err_ack", 32'(bus.o_m_err), 32'h1);
        @(posedge clk); #1;
        bus.i_fault_clr = 1'b0;
        bus.i_m_stb[0] = 1'b0;
        check("t4c_fault_valid", 32'(bus.o_fault_valid), 32'h1);
        check("t4c_fault_addr", bus.o_fault_addr, 32'h2000_0300);

        // Ack coinciding with the timeout count wins
        fault_clear();
        lat[2] = 8'd8;
        xfer(0, 32'h2000_0400, 32'h0, 4'h0, 1'b0, 32'h2222_5A5A);
        check("t5_ack_cycle", 32'(rec_ack_cyc), 32'd9);
        check("t5_no_fault", 32'(bus.o_fault_valid), 32'h0);

        // Asynchronous reset inside the ack cycle
        lat[2] = 8'd3;
        bus.i_m_addr[31:0] = 32'h2000_0500;
        bus.i_m_stb[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_pre_rst_ack", 32'(bus.o_m_ack), 32'h1);
        check("t6_pre_rst_stb", 32'(bus.o_s_stb), 32'h4);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_ack", 32'(bus.o_m_ack), 32'h0);
        check("t6_rst_stb", 32'(bus.o_s_stb), 32'h0);
        check("t6_rst_s_addr", bus.o_s_addr, 32'h0);
        bus.i_m_stb = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        bus.i_m_addr = {32'h1000_0004, 32'h1000_0000};
        push(0, 1'b0, 32'hDEAD_BEEF); push(1, 1'b0, 32'hDEAD_BEEF);
        bus.i_m_stb = 2'b11;
        wait_acks(2, c0, c1, first);
        check("t6_first_after_rst", 32'(first), 32'd0);
        check("t6_acks_m1", 32'(c1), 32'd1);

        @(posedge clk); #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/sba_interconnect.md
# sba_interconnect

Parametrised Simple Bus Architecture (SBA) interconnect that connects up to NUM_MASTERS bus masters (CPU, DMA, debug) to NUM_SLAVES memory-mapped slaves (ROM, BRAM, external bus, timer, …). It arbitrates masters round-robin and decodes slaves from a configurable address bit field. It terminates unmapped and hung transactions with an error acknowledge and captures the fault address. It replaces the hard-wired four-way decode mux at the SoC top level.

## Interface

Parameters:
- NUM_MASTERS, 2, number of master ports (1..4)
- NUM_SLAVES, 4, number of slave ports (1..16)
- SEL_HI, 31, MSB of slave-select field in address
- SEL_LO, 28, LSB of slave-select field; slave index = addr[SEL_HI:SEL_LO]
- TIMEOUT, 255, BUSY cycles without slave ack before error termination; 0 disables
- MW, derived, max(1, clog2(NUM_MASTERS))

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_m_addr  in  32*NUM_MASTERS  master addresses, master k at [32k+31:32k]
- i_m_dat_w  in  32*NUM_MASTERS  master write data
- i_m_we  in  4*NUM_MASTERS  master byte write enables
- i_m_stb  in  NUM_MASTERS  master request strobes
- o_m_ack  out  NUM_MASTERS  per-master acknowledge pulse
- o_m_err  out  NUM_MASTERS  per-master error, valid only with o_m_ack
- o_m_dat_r  out  32  read data, shared; valid with o_m_ack
- o_s_addr, o_s_dat_w, o_s_we  out  32/32/4  granted master's signals, broadcast to all slaves
- o_s_stb  out  NUM_SLAVES  one-hot slave strobe
- i_s_ack  in  NUM_SLAVES  slave acknowledges
- i_s_dat_r  in  32*NUM_SLAVES  slave read data
- o_fault_valid  out  1  sticky fault flag
- o_fault_addr  out  32  address of first captured fault
- o_fault_master  out  MW  master index of first captured fault
- i_fault_clr  in  1  clears o_fault_valid

## Operation

- FSM states: IDLE, BUSY.
- IDLE:
  - If any i_m_stb is set, grant the first requester searching from (last_grant+1) mod NUM_MASTERS. Register grant and go to BUSY.
  - No slave strobe is asserted. i_s_ack is ignored.
- BUSY:
  - o_s_addr, o_s_dat_w and o_s_we are muxed combinationally from the granted master.
  - If the slave index is < NUM_SLAVES, assert o_s_stb[idx].
  - On i_s_ack[idx]: assert o_m_ack[g] the same cycle and drive o_m_dat_r = slave idx data. Update last_grant = g and go to IDLE.
  - If the slave index is ≥ NUM_SLAVES (unmapped): assert no slave strobe. Assert o_m_ack[g] and o_m_err[g] in the first BUSY cycle, then go to IDLE.
  - Timeout: a counter clears on BUSY entry and increments each BUSY cycle. When it equals TIMEOUT (TIMEOUT≠0) with no ack, assert o_m_ack[g] and o_m_err[g], drop the slave strobe, and go to IDLE.
  - Slave ack and timeout in the same cycle: the ack wins and no error is raised.
- Master rule: hold stb, addr, data and we stable until ack is seen. The master may re-assert stb on the next cycle for a new transfer.
- Slave rule: deassert ack within one cycle of stb low. The mandatory IDLE cycle between transfers guarantees stale acks are never consumed.
- Fault capture (unmapped or timeout):
  - If o_fault_valid = 0, load o_fault_addr and o_fault_master, and set valid.
  - If valid is already set, keep the first fault.
  - If i_fault_clr and a new fault occur in the same cycle, capture the new fault and valid stays 1.
- o_m_dat_r = 0 when no ack is asserted or on error.
- Reset (including mid-transaction): state IDLE, last_grant = NUM_MASTERS−1 (so master 0 has first priority), counter 0. All o_m_ack, o_m_err, o_s_stb, o_fault_* = 0. Slave-side data/addr outputs = 0.

## Timing

- Latency, stb to ack: 1 arbitration cycle + slave latency.
  - Example: master stb in cycle 0, granted at edge 1, slave stb in cycle 1, registered slave ack in cycle 2, master ack in cycle 2.
- Back-to-back transfers from one master: minimum 3 cycles per transfer (IDLE, BUSY, BUSY) with 1-cycle slaves.
- Unmapped access: error ack in cycle 1 (first BUSY cycle).
- Timeout: error ack in BUSY cycle TIMEOUT+1.
- o_m_ack and o_m_err are combinational from state and i_s_ack. Grant, counter and fault registers update on the rising i_clk edge.
- o_fault_* update on the edge ending the error-ack cycle.

## Test plan

- Single master, NUM_SLAVES=4. Read 0x1000_0010; slave 1 acks 1 cycle after stb with 0xDEADBEEF → o_s_stb=4'b0010 in cycle 1, o_m_ack[0]=1 and o_m_dat_r=0xDEADBEEF in cycle 2, no error.
- Masters 0 and 1 both hold stb continuously to slave 0 → grants alternate 0,1,0,1. Each master receives exactly one ack per transfer; neither starves.
- Master 1 writes 0x5000_0000 with NUM_SLAVES=4 → no o_s_stb, o_m_ack[1]=o_m_err[1]=1 in cycle 1, o_fault_addr=0x5000_0000, o_fault_master=1, o_fault_valid=1.
- TIMEOUT=8, slave 2 never acks → o_s_stb[2] high for 9 cycles, error ack in BUSY cycle 9. A second hung access leaves o_fault_addr unchanged. i_fault_clr asserted in the same cycle as a third fault → new address captured, valid stays 1.
- TIMEOUT=8, slave acks exactly at counter=8 → normal ack, o_m_err=0, no fault captured.
- Assert i_rst asynchronously mid-BUSY (between clock edges) → o_s_stb and o_m_ack drop immediately. After release, a request from master 0 is granted first.
